// File: rtl/ghist_update.sv
// Speculative global/path history with a checkpoint FIFO. Each accepted branch
// is checkpointed and shifted in; a mispredict restores from the oldest entry.
module ghist_update #(
  parameter int GlobLen   = 131,
  parameter int PLen      = 16,
  parameter int pc_len    = 32,
  parameter int CkptDepth = 8,
  parameter int CkptW     = 3
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               br_valid,
  input  logic               br_taken,
  input  logic [pc_len-1:0]  br_pc,
  output logic               br_ready,
  input  logic               resolve_valid,
  input  logic               resolve_mispredict,
  input  logic               resolve_taken,
  output logic [GlobLen-1:0] ghist,
  output logic [PLen-1:0]    phist,
  output logic               index_tag_enable,
  output logic [CkptW:0]     ckpt_count,
  output logic               resolve_err
);

  typedef enum logic {IDLE, RECOVER} state_t;

  localparam logic [CkptW:0]   CNT_FULL = (CkptW+1)'(CkptDepth);
  localparam logic [CkptW:0]   CNT_ONE  = (CkptW+1)'(1);
  localparam logic [CkptW-1:0] PTR_ONE  = CkptW'(1);

  state_t state;

  logic [GlobLen-1:0]   ckpt_ghist [CkptDepth];
  logic [PLen-1:0]      ckpt_phist [CkptDepth];
  logic [CkptDepth-1:0] ckpt_pcbit;

  logic [CkptW-1:0]   wr_ptr;
  logic [CkptW-1:0]   rd_ptr;
  logic [GlobLen-1:0] rd_ghist;
  logic [PLen-1:0]    rd_phist;
  logic               rd_pcbit;
  logic               empty;
  logic               mispredict;
  logic               accept;
  logic               pop;
  logic               recover;
  logic               unused_bits;

  assign empty      = (ckpt_count == '0);
  assign mispredict = resolve_valid & resolve_mispredict;
  // A mispredict in flight blocks the push so recovery never races a new entry.
  assign br_ready   = (state == IDLE) & (ckpt_count < CNT_FULL) & ~mispredict;
  assign accept     = br_valid & br_ready;
  assign pop        = resolve_valid & ~resolve_mispredict & ~empty;
  assign recover    = mispredict & ~empty;

  assign rd_ghist = ckpt_ghist[rd_ptr];
  assign rd_phist = ckpt_phist[rd_ptr];
  assign rd_pcbit = ckpt_pcbit[rd_ptr];

  // Only PC bit 2 feeds the path history; checkpoint MSBs shift out on restore.
  assign unused_bits = ^{br_pc[pc_len-1:3], br_pc[1:0],
                         rd_ghist[GlobLen-1], rd_phist[PLen-1]};

  // Checkpoint storage: data only, never reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      ckpt_ghist[wr_ptr] <= ghist;
      ckpt_phist[wr_ptr] <= phist;
      ckpt_pcbit[wr_ptr] <= br_pc[2];
    end
  end

  // Control FSM and speculative history registers.
  always_ff @(posedge CLK) begin
    if (!reset) begin
      state            <= IDLE;
      ghist            <= '0;
      phist            <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      ckpt_count       <= '0;
      index_tag_enable <= 1'b0;
      resolve_err      <= 1'b0;
    end else begin
      index_tag_enable <= accept | recover;
      if (resolve_valid & empty)
        resolve_err <= 1'b1;

      if (recover) begin
        ghist      <= {rd_ghist[GlobLen-2:0], resolve_taken};
        phist      <= {rd_phist[PLen-2:0], rd_pcbit};
        rd_ptr     <= wr_ptr;
        ckpt_count <= '0;
        state      <= RECOVER;
      end else begin
        state <= IDLE;
        if (accept) begin
          ghist  <= {ghist[GlobLen-2:0], br_taken};
          phist  <= {phist[PLen-2:0], br_pc[2]};
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop)
          rd_ptr <= rd_ptr + PTR_ONE;
        case ({accept, pop})
          2'b10:   ckpt_count <= ckpt_count + CNT_ONE;
          2'b01:   ckpt_count <= ckpt_count - CNT_ONE;
          default: ckpt_count <= ckpt_count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ghist_update.sv
// Scoreboard bench for ghist_update: a queue-based reference model predicts every
// history update, and a negedge monitor checks each index_tag_enable pulse.
module tb_ghist_update;
  localparam int GL = 131;
  localparam int PL = 16;
  localparam int D  = 8;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          br_valid = 1'b0;
  logic          br_taken = 1'b0;
  logic [31:0]   br_pc = '0;
  logic          br_ready;
  logic          resolve_valid = 1'b0;
  logic          resolve_mispredict = 1'b0;
  logic          resolve_taken = 1'b0;
  logic [GL-1:0] ghist;
  logic [PL-1:0] phist;
  logic          index_tag_enable;
  logic [3:0]    ckpt_count;
  logic          resolve_err;

  always #5 CLK = ~CLK;

  ghist_update #(.GlobLen(GL), .PLen(PL), .pc_len(32), .CkptDepth(D), .CkptW(3)) dut (
    .CLK(CLK), .reset(reset),
    .br_valid(br_valid), .br_taken(br_taken), .br_pc(br_pc), .br_ready(br_ready),
    .resolve_valid(resolve_valid), .resolve_mispredict(resolve_mispredict),
    .resolve_taken(resolve_taken),
    .ghist(ghist), .phist(phist), .index_tag_enable(index_tag_enable),
    .ckpt_count(ckpt_count), .resolve_err(resolve_err)
  );

  typedef struct { logic [GL-1:0] g; logic [PL-1:0] p; logic b; } ent_t;
  typedef struct { logic [GL-1:0] g; logic [PL-1:0] p; } obs_t;

  ent_t          m_q[$];
  obs_t          sb[$];
  logic [GL-1:0] m_g = '0;
  logic [PL-1:0] m_p = '0;
  bit            m_rec = 1'b0;
  bit            m_err = 1'b0;
  int            n_tests = 0;
  int            n_fail = 0;
  int            n_pulse = 0;

  function automatic void check(string name, logic [255:0] got, logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  always @(negedge CLK) begin : monitor
    obs_t e;
    if (reset === 1'b1 && index_tag_enable === 1'b1) begin
      n_pulse++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL spurious_pulse: index_tag_enable=1 with no update expected");
      end else begin
        e = sb.pop_front();
        check("sb_ghist", ghist, e.g);
        check("sb_phist", phist, e.p);
      end
    end
  end

  // One clock of stimulus; the model is advanced at the same rising edge.
  task automatic cyc(input bit bv, input bit bt, input logic [31:0] pc,
                     input bit rv, input bit rm, input bit rt);
    bit   rdy, acc, rec, pop;
    ent_t e;
    @(negedge CLK);
    check("ckpt_count", ckpt_count, m_q.size());
    check("resolve_err", resolve_err, m_err);
    check("ghist", ghist, m_g);
    check("phist", phist, m_p);
    br_valid = bv; br_taken = bt; br_pc = pc;
    resolve_valid = rv; resolve_mispredict = rm; resolve_taken = rt;
    #1;
    rdy = !m_rec && (m_q.size() < D) && !(rv && rm);
    check("br_ready", br_ready, rdy);
    @(posedge CLK);
    acc = bv && rdy;
    rec = rv && rm && (m_q.size() > 0);
    pop = rv && !rm && (m_q.size() > 0);
    if (rv && m_q.size() == 0) m_err = 1'b1;
    if (rec) begin
      e = m_q[0];
      m_q.delete();
      m_g = (e.g << 1) | GL'(rt);
      m_p = (e.p << 1) | PL'(e.b);
      sb.push_back('{g: m_g, p: m_p});
      m_rec = 1'b1;
    end else begin
      m_rec = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_q.push_back('{g: m_g, p: m_p, b: pc[2]});
        m_g = (m_g << 1) | GL'(bt);
        m_p = (m_p << 1) | PL'(pc[2]);
        sb.push_back('{g: m_g, p: m_p});
      end
    end
    #1;
    br_valid = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    reset = 1'b0;
    br_valid = 1'b0; resolve_valid = 1'b0; resolve_mispredict = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    m_g = '0; m_p = '0; m_q.delete(); sb.delete(); m_rec = 1'b0; m_err = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    #1;
    check("rst_ghist", ghist, 0);
    check("rst_phist", phist, 0);
    check("rst_count", ckpt_count, 0);
    check("rst_err", resolve_err, 0);
    check("rst_ite", index_tag_enable, 0);
    check("rst_ready", br_ready, 1);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int p0;
    do_reset();

    // Three pushes: T/N/T with pc bit 2 = 1/0/1.
    p0 = n_pulse;
    cyc(1, 1, 32'h0000_0004, 0, 0, 0);
    cyc(1, 0, 32'h0000_0000, 0, 0, 0);
    cyc(1, 1, 32'h0000_1004, 0, 0, 0);
    @(negedge CLK); #1;
    check("r37_ghist", ghist[2:0], 3'b101);
    check("r37_phist", phist[2:0], 3'b101);
    check("r37_count", ckpt_count, 3);
    check("r37_pulses", n_pulse - p0, 3);

    // Fill to capacity, offer a 9th, then a correct resolve while full.
    do_reset();
    for (int i = 0; i < D; i++) cyc(1, $urandom_range(0, 1), $urandom, 0, 0, 0);
    cyc(1, 1, 32'h4, 0, 0, 0);
    check("r38_count_full", ckpt_count, 8);
    cyc(1, 1, 32'h4, 1, 0, 0);
    cyc(1, 0, 32'h0, 0, 0, 0);
    idle(1);

    // Mispredict after two taken pushes; RECOVER cycle offers a branch.
    do_reset();
    p0 = n_pulse;
    cyc(1, 1, 32'h0, 0, 0, 0);
    cyc(1, 1, 32'h0, 0, 0, 0);
    cyc(0, 0, 32'h0, 1, 1, 0);
    cyc(1, 1, 32'h4, 0, 0, 0);
    check("r39_ghist", ghist, 0);
    check("r39_pulses", n_pulse - p0, 3);
    idle(2);

    // Simultaneous push and correct resolve at four outstanding.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 1, 32'h4, 0, 0, 0);
    cyc(1, 0, 32'h4, 1, 0, 0);
    @(negedge CLK); #1;
    check("r40_count", ckpt_count, 4);
    check("r40_ghist", ghist[4:0], 5'b11110);

    // Resolve with nothing outstanding sets the sticky error.
    do_reset();
    cyc(0, 0, 32'h0, 1, 0, 0);
    cyc(0, 0, 32'h0, 1, 1, 1);
    idle(2);
    @(negedge CLK); #1;
    check("r41_err", resolve_err, 1);
    check("r41_ghist", ghist, 0);
    do_reset();

    // Reset arriving during the RECOVER cycle.
    cyc(1, 1, 32'h4, 0, 0, 0);
    cyc(1, 0, 32'h0, 0, 0, 0);
    cyc(0, 0, 32'h0, 1, 1, 1);
    do_reset();
    idle(1);

    // Twenty pushes interleaved with correct resolves, wrapping the pointers.
    for (int i = 0; i < 20; i++)
      cyc(1, $urandom_range(0, 1), $urandom, (i % 3 != 0) && (m_q.size() > 0), 0, 0);
    cyc(0, 0, 32'h0, 1, 1, 1);
    idle(1);

    // Random traffic with occasional mispredicts.
    for (int i = 0; i < 400; i++) begin
      bit rv, rm;
      rv = ($urandom_range(0, 2) == 0) && (m_q.size() > 0);
      rm = rv && ($urandom_range(0, 7) == 0);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom, rv, rm,
          $urandom_range(0, 1));
    end
    idle(3);
    @(negedge CLK); #2;
    check("sb_drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ghist_update.md
GHIST_UPDATE -- requirements
Module: ghist_update

Interface
REQ-001 SHALL have parameter GlobLen, default 131, meaning the global history width.
REQ-002 SHALL have parameter PLen, default 16, meaning the path history width.
REQ-003 SHALL have parameter pc_len, default 32, meaning the branch PC width.
REQ-004 SHALL have parameter CkptDepth, default 8, meaning the number of checkpoint entries (power of 2).
REQ-005 SHALL have parameter CkptW, default 3, equal to log2(CkptDepth).
REQ-006 SHALL have port CLK, input, 1 bit: clock; all state updates occur on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port br_valid, input, 1 bit: a new predicted branch is offered.
REQ-009 SHALL have port br_taken, input, 1 bit: the predicted direction of the offered branch.
REQ-010 SHALL have port br_pc, input, pc_len bits: the PC of the offered branch.
REQ-011 SHALL have port br_ready, output, 1 bit: combinational; the block accepts the offered branch.
REQ-012 SHALL have port resolve_valid, input, 1 bit: the oldest outstanding branch is resolved.
REQ-013 SHALL have port resolve_mispredict, input, 1 bit: the resolved branch was mispredicted.
REQ-014 SHALL have port resolve_taken, input, 1 bit: the actual direction of the resolved branch.
REQ-015 SHALL have port ghist, output, GlobLen bits: the speculative global history; bit 0 is the newest outcome.
REQ-016 SHALL have port phist, output, PLen bits: the speculative path history; bit 0 is the newest entry.
REQ-017 SHALL have port index_tag_enable, output, 1 bit: a one-cycle pulse marking that ghist/phist have changed.
REQ-018 SHALL have port ckpt_count, output, CkptW+1 bits: the number of outstanding checkpoints.
REQ-019 SHALL have port resolve_err, output, 1 bit: sticky flag set when a resolve arrives with no outstanding checkpoint.

Function
REQ-020 SHALL implement a two-state FSM with states IDLE and RECOVER.
REQ-021 SHALL drive br_ready = (state==IDLE) & (ckpt_count<CkptDepth) & ~(resolve_valid & resolve_mispredict).
REQ-022 SHALL perform an accept when br_valid & br_ready is high at a rising edge.
REQ-023 On accept, SHALL write {ghist, phist, br_pc[2]} into the checkpoint FIFO at the write pointer, then increment the write pointer modulo CkptDepth.
REQ-024 On accept, SHALL load ghist <= {ghist[GlobLen-2:0], br_taken} and phist <= {phist[PLen-2:0], br_pc[2]}.
REQ-025 SHALL register index_tag_enable so that it is high exactly in the cycle the updated ghist/phist first appear (one cycle after the accepting edge), and low otherwise, except as stated in REQ-029.
REQ-026 On resolve_valid & ~resolve_mispredict with ckpt_count>0, SHALL pop the oldest entry (read pointer +1 modulo CkptDepth) and leave ghist/phist unchanged.
REQ-027 On resolve_valid & resolve_mispredict with ckpt_count>0, SHALL restore from the oldest entry E: ghist <= {E.ghist[GlobLen-2:0], resolve_taken} and phist <= {E.phist[PLen-2:0], E.pcbit}.
REQ-028 On a mispredict recovery, SHALL flush all checkpoints (read pointer = write pointer, ckpt_count=0) and set state to RECOVER.
REQ-029 SHALL stay in RECOVER for exactly one cycle, hold br_ready=0 during it, pulse index_tag_enable during it, and then return to IDLE.
REQ-030 When a push and a correct-prediction pop occur in the same cycle, SHALL perform both and leave ckpt_count unchanged.
REQ-031 SHALL ignore br_valid during a mispredict resolve (no push, no history shift); the mispredict takes priority.
REQ-032 When full (ckpt_count==CkptDepth), SHALL hold br_ready=0 even if a pop occurs that cycle; pushing resumes the following cycle.
REQ-033 On resolve_valid with ckpt_count==0, SHALL change no state and set resolve_err=1 until reset.
REQ-034 SHALL let pointers wrap modulo CkptDepth, with ckpt_count tracked separately in the range 0..CkptDepth.

Reset
REQ-035 When reset==0 at a rising edge, SHALL clear ghist, phist, the pointers, ckpt_count, index_tag_enable and resolve_err to 0, and set state to IDLE.
REQ-036 SHALL let reset override all concurrent activity, including mid-RECOVER; checkpoint storage contents need not be cleared.

Verification
REQ-037 After reset, push taken/not-taken/taken with br_pc[2]=1,0,1 -> ghist[2:0]=3'b101, phist[2:0]=3'b101, ckpt_count=3, three index_tag_enable pulses.
REQ-038 Push 8 branches with no resolves -> br_ready=0 and ckpt_count=8; a 9th br_valid is not accepted; one correct resolve -> ckpt_count=7 and br_ready returns to 1 the next cycle.
REQ-039 With ghist=0, push taken, taken, then mispredict resolve with resolve_taken=0 -> ghist=0, ckpt_count=0, RECOVER lasts one cycle with br_ready=0 and index_tag_enable=1.
REQ-040 Simultaneous push and correct resolve at ckpt_count=4 -> ckpt_count stays 4 and ghist shifts by one.
REQ-041 Resolve with ckpt_count=0 -> resolve_err=1 and ghist unchanged; reset -> resolve_err=0.
REQ-042 Push 20 branches interleaved with correct resolves (pointer wrap) -> each pop returns its matching entry; compare against a model.
